// File: rtl/pi_req_sync.sv
// pi_req_sync: Pi launch-strobe capture, c7m synchroniser and request FSM
// feeding the 68K bus transfer state machine.
// Optional watchdog: define PI_REQ_SYNC_TIMEOUT_EN to build the TIMEOUT
// state, force_dtack and timeout. Without it both outputs are tied low and
// PEND/ACTIVE wait until op_reqrst.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; counter held at zero
// PEND    | op_req raised, waiting for the bus FSM to assert AS
// ACTIVE  | bus cycle running; waiting for op_reqrst from the bus FSM
// TMO     | watchdog fired; force_dtack/timeout held until op_reqrst
module pi_req_sync #(
   parameter int unsigned TIMEOUT_CYCLES = 200,
   parameter int unsigned CNT_W          = 8,
   parameter logic [1:0]  LAUNCH_ADDR    = 2'd2
) (
   input  logic             c7m,
   input  logic             op_reqrst,
   input  logic             pi_wr,
   input  logic [1:0]       pi_a,
   input  logic             bus_active,
   output logic             op_req,
   output logic             start,
   output logic             txn_in_progress,
   output logic             force_dtack,
   output logic             timeout,
   output logic [CNT_W-1:0] wait_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      ACTIVE = 2'd2,
      TMO    = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             req_raw;
   logic             req_s1;
   logic             req_s2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             cnt_sat;
   logic             start_q;

   assign cnt_sat = &cnt;

   // Launch capture in the Pi strobe domain; only reset clears it, so a
   // repeated strobe during a transaction cannot start a second one.
   always_ff @(posedge pi_wr or posedge op_reqrst) begin
      if (op_reqrst) begin
         req_raw <= 1'b0;
      end else if (pi_a == LAUNCH_ADDR) begin
         req_raw <= 1'b1;
      end
   end

`ifdef PI_REQ_SYNC_TIMEOUT_EN
   logic hit;
   logic tmo_q;

   // Compare against TIMEOUT_CYCLES-1 so TIMEOUT is entered exactly
   // TIMEOUT_CYCLES cycles after PEND entry.
   assign hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_tc;

   // The watchdog length only matters when the watchdog is built.
   assign unused_tc = TIMEOUT_CYCLES;
`endif

   // Next-state and counter update.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (req_s2) begin
               state_nx = PEND;
            end
         end
         PEND, ACTIVE: begin
            if (!cnt_sat) begin
               cnt_nx = cnt + 1'b1;
            end
            if ((state == PEND) && bus_active) begin
               state_nx = ACTIVE;
            end
`ifdef PI_REQ_SYNC_TIMEOUT_EN
            if (hit) begin
               state_nx = TMO;
               cnt_nx   = cnt;
            end
`endif
         end
         TMO: begin
            state_nx = TMO;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Synchroniser, state, counter and registered start pulse.
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         req_s1  <= 1'b0;
         req_s2  <= 1'b0;
         state   <= IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
      end else begin
         req_s1  <= req_raw;
         req_s2  <= req_s1;
         state   <= state_nx;
         cnt     <= cnt_nx;
         start_q <= (state == IDLE) && (state_nx == PEND);
      end
   end

`ifdef PI_REQ_SYNC_TIMEOUT_EN
   // Registered watchdog flag so force_dtack is glitch-free.
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         tmo_q <= 1'b0;
      end else begin
         tmo_q <= (state_nx == TMO);
      end
   end

   assign force_dtack = tmo_q;
   assign timeout     = tmo_q;
`else
   assign force_dtack = 1'b0;
   assign timeout     = 1'b0;
`endif

   assign op_req          = (state != IDLE);
   assign start           = start_q;
   assign txn_in_progress = req_raw | (state != IDLE);
   assign wait_cnt        = cnt;

endmodule

// File: tb/tb_pi_req_sync.sv
// tb_pi_req_sync: randomized and directed stimulus for pi_req_sync, checked
// every c7m negedge against a transaction-level model (time since launch,
// time since PEND entry).
module tb_pi_req_sync;

   localparam int          TC = 40;
   localparam logic [1:0]  LA = 2'd2;
`ifdef PI_REQ_SYNC_TIMEOUT_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic       c7m;
   logic       op_reqrst;
   logic       pi_wr;
   logic [1:0] pi_a;
   logic       bus_active;
   logic       op_req;
   logic       start;
   logic       txn_in_progress;
   logic       force_dtack;
   logic       timeout;
   logic [7:0] wait_cnt;

   int checks   = 0;
   int failures = 0;

   pi_req_sync #(
      .TIMEOUT_CYCLES (TC),
      .CNT_W          (8),
      .LAUNCH_ADDR    (LA)
   ) dut (
      .c7m             (c7m),
      .op_reqrst       (op_reqrst),
      .pi_wr           (pi_wr),
      .pi_a            (pi_a),
      .bus_active      (bus_active),
      .op_req          (op_req),
      .start           (start),
      .txn_in_progress (txn_in_progress),
      .force_dtack     (force_dtack),
      .timeout         (timeout),
      .wait_cnt        (wait_cnt)
   );

   initial c7m = 1'b0;
   always #5 c7m = ~c7m;

   // Model: launched flag, c7m edges seen since launch, and whether/how long
   // ago the request was presented (3rd edge after the strobe).
   bit m_raw;
   int m_edges;
   bit m_in;
   int m_cyc;

   always @(posedge op_reqrst) begin
      m_raw   = 1'b0;
      m_edges = 0;
      m_in    = 1'b0;
      m_cyc   = 0;
   end

   always @(posedge pi_wr) begin
      if (!op_reqrst && (pi_a == LA)) m_raw = 1'b1;
   end

   always @(posedge c7m) begin
      if (!op_reqrst) begin
         if (m_in) begin
            m_cyc++;
         end else if (m_raw) begin
            m_edges++;
            if (m_edges == 3) begin
               m_in  = 1'b1;
               m_cyc = 0;
            end
         end
      end
   end

   function automatic int min2(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge c7m) begin
      int e_cnt;
      bit e_tmo;
      e_tmo = FEAT && m_in && (m_cyc >= TC);
      if (!m_in)      e_cnt = 0;
      else if (FEAT)  e_cnt = min2(m_cyc, TC - 1);
      else            e_cnt = min2(m_cyc, 255);
      chk("op_req",          int'(op_req),          int'(m_in));
      chk("start",           int'(start),           int'(m_in && (m_cyc == 0)));
      chk("txn_in_progress", int'(txn_in_progress), int'(m_raw || m_in));
      chk("force_dtack",     int'(force_dtack),     int'(e_tmo));
      chk("timeout",         int'(timeout),         int'(e_tmo));
      chk("wait_cnt",        int'(wait_cnt),        e_cnt);
   end

   task automatic step(int n);
      repeat (n) @(negedge c7m);
      #2;
   endtask

   task automatic strobe(logic [1:0] a);
      pi_a  = a;
      pi_wr = 1'b1;
      #1;
      pi_wr = 1'b0;
   endtask

   task automatic rst_pulse(int n);
      op_reqrst = 1'b1;
      #1;
      chk("rst_op_req", int'(op_req), 0);
      chk("rst_txn",    int'(txn_in_progress), 0);
      chk("rst_start",  int'(start), 0);
      chk("rst_cnt",    int'(wait_cnt), 0);
      step(n);
      op_reqrst  = 1'b0;
      bus_active = 1'b0;
   endtask

   task automatic launch_check();
      pi_a  = LA;
      pi_wr = 1'b1;
      #1;
      chk("launch_txn_now", int'(txn_in_progress), 1);
      pi_wr = 1'b0;
      step(1);
      chk("launch_edge1_req", int'(op_req), 0);
      step(1);
      chk("launch_edge2_req", int'(op_req), 0);
      step(1);
      chk("launch_edge3_req",   int'(op_req), 1);
      chk("launch_edge3_start", int'(start), 1);
      bus_active = 1'b1;
      step(1);
      chk("launch_start_once", int'(start), 0);
      step(5);
      chk("launch_cnt6", int'(wait_cnt), 6);
      rst_pulse(1);
      step(1);
      chk("post_rst_cnt", int'(wait_cnt), 0);
      chk("post_rst_txn", int'(txn_in_progress), 0);
   endtask

   initial begin
      op_reqrst  = 1'b0;
      pi_wr      = 1'b0;
      pi_a       = 2'd0;
      bus_active = 1'b0;
      #1;
      op_reqrst  = 1'b1;
      step(2);
      op_reqrst  = 1'b0;
      step(1);

      // basic launch
      launch_check();

      // other addresses are ignored
      for (int k = 0; k < 4; k++) begin
         if (k != int'(LA)) begin
            strobe(2'(k));
            step(20);
            chk("noaddr_req", int'(op_req), 0);
            chk("noaddr_txn", int'(txn_in_progress), 0);
         end
      end

      // watchdog / saturation with bus_active high and no op_reqrst
      strobe(LA);
      bus_active = 1'b1;
      step(3);
      chk("wd_entry_start", int'(start), 1);
`ifdef PI_REQ_SYNC_TIMEOUT_EN
      step(TC - 1);
      chk("wd_pre_timeout", int'(timeout), 0);
      chk("wd_pre_cnt",     int'(wait_cnt), TC - 1);
      step(1);
      chk("wd_timeout",     int'(timeout), 1);
      chk("wd_force",       int'(force_dtack), 1);
      chk("wd_cnt_frozen",  int'(wait_cnt), TC - 1);
      step(10);
      chk("wd_cnt_hold",    int'(wait_cnt), TC - 1);
`else
      step(300);
      chk("sat_cnt",   int'(wait_cnt), 255);
      chk("sat_force", int'(force_dtack), 0);
      chk("sat_req",   int'(op_req), 1);
`endif
      rst_pulse(1);
      step(2);

      // reset mid-PEND
      strobe(LA);
      step(4);
      rst_pulse(1);
      step(5);
      chk("abort_req", int'(op_req), 0);

      // reset coincident with the launch edge
      op_reqrst = 1'b1;
      pi_a      = LA;
      pi_wr     = 1'b1;
      #1;
      chk("coinc_txn", int'(txn_in_progress), 0);
      step(1);
      op_reqrst = 1'b0;
      pi_wr     = 1'b0;
      step(6);
      chk("coinc_req", int'(op_req), 0);
      chk("coinc_txn_late", int'(txn_in_progress), 0);

      // second strobe while ACTIVE
      strobe(LA);
      step(3);
      bus_active = 1'b1;
      step(2);
      strobe(LA);
      step(5);
      chk("dup_cnt",   int'(wait_cnt), 7);
      chk("dup_start", int'(start), 0);
      rst_pulse(1);
      step(1);
      launch_check();

      // randomized transactions
      for (int it = 0; it < 30; it++) begin
         step($urandom_range(0, 3));
         bus_active = 1'($urandom_range(0, 1));
         strobe(($urandom_range(0, 1) == 1) ? LA : 2'($urandom_range(0, 3)));
         for (int c = int'($urandom_range(0, 60)); c > 0; c--) begin
            step(1);
            bus_active = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) strobe(2'($urandom_range(0, 3)));
         end
         rst_pulse($urandom_range(1, 3));
      end

      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
